// File: rtl/frv_mem_responder_pkg.sv
// Shared types and constants for the frv_mem_responder memory model.
// The response queue entry, latency counter width and stall LFSR constants live here.
package frv_mem_responder_pkg;

    localparam int LAT_W = 4;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic        error;
        logic [31:0] rdata;
    } resp_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/frv_mem_resp_fifo.sv
// In-order response queue with a per-entry countdown that gates when the head
// becomes visible; countdowns load LATENCY on push and tick down every cycle.
module frv_mem_resp_fifo
    import frv_mem_responder_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int LATENCY = 1
) (
    input  logic  g_clk,
    input  logic  g_resetn,
    input  logic  push,
    input  resp_t push_data,
    input  logic  pop,
    output logic  full,
    output logic  empty,
    output logic  head_ready,
    output resp_t head_data
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY);

    resp_t            data_q [DEPTH];
    logic [LAT_W-1:0] cd_q   [DEPTH];
    logic [LAT_W-1:0] cd_d   [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign do_push    = push & ~full;
    assign do_pop     = pop & ~empty;
    assign head_data  = data_q[rd_ptr_q];
    assign head_ready = (cd_q[rd_ptr_q] == '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            cd_d[i] = (cd_q[i] != '0) ? cd_q[i] - 1'b1 : '0;
        end
        if (do_push) begin
            cd_d[wr_ptr_q] = LAT_LOAD;
            wr_ptr_d       = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                cd_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                cd_q[i] <= cd_d[i];
            end
        end
    end

    // Payload storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge g_clk) begin
        if (do_push) begin
            data_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/frv_mem_responder.sv
// Word-addressed memory responder for one frv_core memory port (req/gnt in, recv/ack out).
// Define FRV_MEM_RESPONDER_STALL_EN to add LFSR-driven random gnt/recv stalls.
module frv_mem_responder
    import frv_mem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          OUTSTANDING = 2,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        mem_req,
    input  logic        mem_wen,
    input  logic [3:0]  mem_strb,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_addr,
    output logic        mem_gnt,
    output logic        mem_recv,
    input  logic        mem_ack,
    output logic        mem_error,
    output logic [31:0] mem_rdata
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [29:0]      word_off;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic             accept, pop, wr_en;
    logic             full, empty, head_ready;
    logic             stall_gnt, stall_recv;
    logic [31:0]      rd_word;
    resp_t            push_data, head_data;

    // BASE_ADDR is aligned, so the word offset is just the difference of word addresses.
    assign word_off = mem_addr[31:2] - BASE_ADDR[31:2];
    assign in_range = (mem_addr >= BASE_ADDR) && ({2'b00, word_off} < 32'(DEPTH_WORDS));
    assign idx      = word_off[IDX_W-1:0];

    assign accept = mem_req & mem_gnt;
    assign wr_en  = accept & mem_wen & in_range;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_q [DEPTH_WORDS];

        always_ff @(posedge g_clk) begin
            if (wr_en && mem_strb[gi]) begin
                lane_q[idx] <= mem_wdata[gi*8 +: 8];
            end
        end

        assign rd_word[gi*8 +: 8] = lane_q[idx];
    end

    always_comb begin
        push_data.error = ~in_range;
        push_data.rdata = (in_range && !mem_wen) ? rd_word : '0;
    end

    frv_mem_resp_fifo #(
        .DEPTH   (OUTSTANDING),
        .LATENCY (LATENCY)
    ) u_fifo (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .push       (accept),
        .push_data  (push_data),
        .pop        (pop),
        .full       (full),
        .empty      (empty),
        .head_ready (head_ready),
        .head_data  (head_data)
    );

`ifdef FRV_MEM_RESPONDER_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall_gnt  = lfsr_q[0];
    assign stall_recv = lfsr_q[1];
`else
    assign stall_gnt  = 1'b0;
    assign stall_recv = 1'b0;
`endif

    // No pass-through: a full queue refuses even when the head pops this cycle.
    assign mem_gnt   = g_resetn & ~full & ~stall_gnt;
    assign mem_recv  = ~empty & head_ready & ~stall_recv;
    assign pop       = mem_recv & mem_ack;
    assign mem_error = ~empty & head_data.error;
    assign mem_rdata = empty ? '0 : head_data.rdata;

endmodule
